// File: rtl/tdc_pkg.sv
// Shared types and sizes for the tapped-delay-line TDC.
`timescale 1ns/1ps
package tdc_pkg;
  localparam int unsigned N_TAPS   = 32;
  localparam int unsigned FINE_W   = $clog2(N_TAPS);
  localparam int unsigned COARSE_W = 4;

  typedef enum logic {
    IDLE,
    ARMED
  } state_t;

  typedef logic [N_TAPS-1:0] therm_t;
endpackage

// File: rtl/tdc_therm2bin.sv
// Thermometer to binary: count of consecutive ones from bit 0, clamped to N_TAPS-1.
`timescale 1ns/1ps
module tdc_therm2bin
  import tdc_pkg::*;
(
  input  therm_t            therm,
  output logic [FINE_W-1:0] bin
);

  logic            run;
  logic [FINE_W:0] ones;

  always_comb begin
    run  = 1'b1;
    ones = '0;
    for (int unsigned i = 0; i < N_TAPS; i++) begin
      run  = run & therm[i];
      ones = ones + {{FINE_W{1'b0}}, run};
    end
    bin = (ones > (FINE_W+1)'(N_TAPS-1)) ? FINE_W'(N_TAPS-1) : ones[FINE_W-1:0];
  end

endmodule

// File: rtl/tdc.sv
// Hit-pulse width TDC: 100 MHz coarse count plus fine start/stop bins from two delay lines.
// Define TDC_SATURATE_EN to saturate the coarse count at 15 instead of wrapping.
`timescale 1ns/1ps
module tdc
  import tdc_pkg::*;
#(
  parameter real TAP_DELAY = 0.3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hit,
  output logic [FINE_W-1:0]   bin_out_start,
  output logic [FINE_W-1:0]   bin_out_stop,
  output logic [COARSE_W-1:0] out_count
);

  logic line_h [N_TAPS+1];
  logic line_n [N_TAPS+1];

  assign line_h[0] = hit;
  assign line_n[0] = ~hit;

  generate
    for (genvar i = 1; i <= N_TAPS; i++) begin : g_tap
`ifdef SYNTHESIS
      assign line_h[i] = line_h[i-1];
      assign line_n[i] = line_n[i-1];
`else
      assign #(TAP_DELAY) line_h[i] = line_h[i-1];
      assign #(TAP_DELAY) line_n[i] = line_n[i-1];
`endif
    end
  endgenerate

  therm_t taps_h, taps_n;

  always_comb begin
    taps_h = '0;
    taps_n = '0;
    for (int unsigned i = 0; i < N_TAPS; i++) begin
      taps_h[i] = line_h[i+1];
      taps_n[i] = line_n[i+1];
    end
  end

  therm_t     therm_s, therm_p;
  logic [2:0] h_hist;
  logic [2:0] vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      therm_s <= '0;
      therm_p <= '0;
      h_hist  <= '0;
      vld     <= '0;
    end else begin
      therm_s <= taps_h;
      therm_p <= taps_n;
      h_hist  <= {h_hist[1:0], line_h[0]};
      vld     <= {vld[1:0], 1'b1};
    end
  end

  // A start needs two low samples before it: enforces stop-to-start spacing
  // and rejects a hit that was already high when reset released.
  logic quiet, rise, fall, runt;

  assign quiet = vld[2] & ~h_hist[1] & ~h_hist[2];
  assign rise  = quiet & h_hist[0];
  assign runt  = quiet & ~h_hist[0] & (|therm_s);
  assign fall  = h_hist[1] & ~h_hist[0];

  // A sub-cycle pulse has already left the head of the line; its start edge
  // is the far end of the first run of ones, so leading zeros are filled.
  therm_t fill, start_vec;
  logic   seen;

  always_comb begin
    seen = 1'b0;
    fill = '0;
    for (int unsigned i = 0; i < N_TAPS; i++) begin
      fill[i] = therm_s[i] | ~seen;
      seen    = seen | therm_s[i];
    end
    start_vec = h_hist[0] ? therm_s : fill;
  end

  logic [FINE_W-1:0] start_bin, stop_bin;

  tdc_therm2bin u_start_bin (
    .therm (start_vec),
    .bin   (start_bin)
  );

  tdc_therm2bin u_stop_bin (
    .therm (therm_p),
    .bin   (stop_bin)
  );

  state_t state, state_nx;
  logic   start_ld, stop_ld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start_ld = 1'b0;
    stop_ld  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nx = ARMED;
          start_ld = 1'b1;
        end else if (runt) begin
          start_ld = 1'b1;
          stop_ld  = 1'b1;
        end
      end
      ARMED: begin
        if (fall) begin
          state_nx = IDLE;
          stop_ld  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  logic [FINE_W-1:0]   start_code;
  logic [COARSE_W-1:0] cnt, cnt_inc;

  always_comb begin
`ifdef TDC_SATURATE_EN
    cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
`else
    cnt_inc = cnt + 1'b1;
`endif
  end

  // Events are acted on one edge after capture, so cnt counts edges since Cs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      start_code    <= '0;
      bin_out_start <= '0;
      bin_out_stop  <= '0;
      out_count     <= '0;
    end else begin
      cnt <= (state == IDLE) ? COARSE_W'(1) : cnt_inc;
      if (start_ld) start_code <= start_bin;
      if (stop_ld) begin
        bin_out_start <= (state == IDLE) ? start_bin : start_code;
        bin_out_stop  <= stop_bin;
        out_count     <= (state == IDLE) ? '0 : cnt;
      end
    end
  end

endmodule

// File: tb/tb_tdc.sv
// Directed bench for tdc: pulse timings with hand-computed fine bins and coarse counts.
`timescale 1ns/1ps
module tb_tdc;
  logic       clk;
  logic       rst;
  logic       hit;
  logic [4:0] bin_out_start;
  logic [4:0] bin_out_stop;
  logic [3:0] out_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

`ifdef TDC_SATURATE_EN
  localparam int unsigned C1 = 15;
  localparam int unsigned C2 = 15;
`else
  localparam int unsigned C1 = 0;
  localparam int unsigned C2 = 9;
`endif

  tdc #(.TAP_DELAY(0.3)) dut (
    .clk           (clk),
    .rst           (rst),
    .hit           (hit),
    .bin_out_start (bin_out_start),
    .bin_out_stop  (bin_out_stop),
    .out_count     (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input int unsigned s, input int unsigned p,
                         input int unsigned c);
    chk({tag, ".start"}, int'(bin_out_start), s);
    chk({tag, ".stop"},  int'(bin_out_stop),  p);
    chk({tag, ".count"}, int'(out_count),     c);
  endtask

  task automatic at(input realtime t);
    #(t - $realtime);
  endtask

  // Hit edges sit 1 ps ahead of their nominal times so edges that land on a
  // clock edge or a tap boundary are sampled deterministically.
  initial begin
    rst = 1'b1;
    hit = 1'b0;
    at(3);        hit = 1'b1;
    at(8);        hit = 1'b0;
    at(10);       chk_out("in_reset", 0, 0, 0);
    at(13);       hit = 1'b1;
    at(20);       rst = 1'b0;
    at(22);       chk_out("post_reset", 0, 0, 0);
    at(60);       hit = 1'b0;
    at(100);      chk_out("high_at_release", 0, 0, 0);

    at(121.999);  hit = 1'b1;
    at(280.999);  hit = 1'b0;
    at(290);      chk_out("p1_latency", 0, 0, 0);
    at(297);      chk_out("p1", 10, 13, C1);

    at(512.999);  hit = 1'b1;
    at(600);      chk_out("p1_hold", 10, 13, C1);
    at(755.999);  hit = 1'b0;
    at(777);      chk_out("p2", 6, 30, C2);

    at(1000.999); hit = 1'b1;
    at(1002.999); hit = 1'b0;
    at(1017);     chk_out("short", 13, 6, 0);

    at(1200.999); hit = 1'b1;
    at(1250);     rst = 1'b1;
    at(1260);     rst = 1'b0;
    at(1262);     chk_out("mid_rst", 0, 0, 0);
    at(1299.999); hit = 1'b0;
    at(1390);     chk_out("after_rst", 0, 0, 0);

    at(1404.999); hit = 1'b1;
    at(1475.099); hit = 1'b0;
    at(1497);     chk_out("mid_range", 0, 31, 8);

    at(1620.999); hit = 1'b1;
    at(1650.999); hit = 1'b0;
    at(1662.999); hit = 1'b1;
    at(1667);     chk_out("p3", 13, 13, 3);
    at(1682.999); hit = 1'b0;
    at(1700);     chk_out("close_start", 13, 13, 3);
    at(1702.999); hit = 1'b1;
    at(1741.999); hit = 1'b0;
    at(1757);     chk_out("p4", 6, 10, 4);

    at(1800);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tdc.md
# tdc

Tapped-delay-line time-to-digital converter measuring the width of each `hit` pulse. Uses a 100 MHz coarse counter plus a 32-tap fine interpolator for both edges. The rising edge of `hit` is the start event; the falling edge is the stop event. The block sits directly behind the hit input pin and feeds a readout/histogram stage with coarse cycles plus fine start/stop bins.

## Interface
- `N_TAPS`, 32: delay-line taps per edge; fine code width is log2(N_TAPS).
- `TAP_DELAY`, 0.3 (ns): per-tap delay of the simulation delay-line model; ignored in synthesis, where the line maps to carry-chain cells.
- `clk`  in  1  system clock, 100 MHz (10 ns period, rising edge active).
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `hit`  in  1  asynchronous level input; rise = start, fall = stop.
- `bin_out_start`  out  5  fine code of the start edge.
- `bin_out_stop`  out  5  fine code of the stop edge.
- `out_count`  out  4  coarse clock cycles between start capture and stop capture.

## Operation
- Two delay lines of `N_TAPS` taps, one carrying `hit` and one carrying `~hit`, each sampled into a thermometer register on every `clk` rising edge.
- Fine code = number of consecutive ones counted from tap 0 up to the first zero, clamped to 31.
  - Bubbles beyond the first zero are ignored.
  - Equivalent to floor((t_edge_capture − t_hit_edge) / TAP_DELAY).
- Cs = first clk rising edge after `hit` rises; tap-0 sample of `hit` becomes 1. Fine start code is latched internally at Cs.
- Ce = first clk rising edge after `hit` falls; tap-0 sample of `~hit` becomes 1. Fine stop code is latched at Ce.
- Coarse counter:
  - Clears at Cs and increments on each edge after Cs.
  - Value at Ce is (Ce − Cs) / 10 ns.
  - 4-bit, wraps modulo 16 by default.
- Output register: `bin_out_start`, `bin_out_stop`, `out_count` all load together one cycle after Ce. Held until the next completed measurement.
- Two-state FSM:
  - IDLE → ARMED on start capture.
  - ARMED → IDLE on stop capture, with output load.
- Pulse with Cs == Ce (width < 1 cycle): `out_count` = 0, fine codes still reported.
- `hit` already high when `rst` deasserts: not counted as a start; the first measurement begins on the next rising edge.
- Interval reconstruction (downstream): T = out_count·10 ns + (bin_out_start − bin_out_stop)·TAP_DELAY.

## Timing
- `rst` asserted, any time: all outputs = 0, FSM = IDLE, thermometer and edge-detect registers cleared. Any measurement in progress is discarded.
- Latency: outputs valid at Ce + 1 cycle.
- Start capture requires a tap-0 0→1 transition of `hit` seen between consecutive edges; stop capture requires the same on `~hit`.
- Minimum spacing between stop and the next start: 2 cycles. Closer starts are ignored.

## Configuration
- `TDC_SATURATE_EN` defined: coarse counter saturates at 15. Any pulse of 15 or more cycles reports `out_count` = 15.
- Not defined: counter wraps modulo 16.

## Structure
- Shared package `tdc_pkg`: `N_TAPS`, `FINE_W` = 5, `COARSE_W` = 4, FSM state enum (IDLE, ARMED), typedef for the thermometer vector.
- One sub-module, `tdc_therm2bin`: 32-bit thermometer → 5-bit leading-ones count with clamp. Instantiated twice (start and stop).
- Delay line is a `generate` chain inside `tdc`.

## Test plan
Clock from a 100 MHz generator, clk low at t = 0, rising edges at 5 + 10k ns; `TAP_DELAY` = 0.3 ns.
- Reset: `rst` high 0–20 ns → all outputs 0; `hit` toggling during reset → no output change.
- Pulse 1: `hit` ↑ at 122 ns, ↓ at 281 ns (Cs = 125, Ce = 285).
  - Required: `bin_out_start` = 10, `bin_out_stop` = 13.
  - `out_count` = 0 (wrap) or 15 (`TDC_SATURATE_EN`), all valid at 295 ns.
- Pulse 2: `hit` ↑ at 513 ns, ↓ at 756 ns (Cs = 515, Ce = 765).
  - Required: `bin_out_start` = 6, `bin_out_stop` = 30.
  - `out_count` = 9 (wrap) or 15 (saturate).
- Short pulse: `hit` ↑ at 1001 ns, ↓ at 1003 ns → `out_count` = 0, `bin_out_start` = 13, `bin_out_stop` = 6.
- Mid-measurement reset: `hit` ↑ at 1201 ns, `rst` pulse at 1250 ns, `hit` ↓ at 1300 ns → outputs 0, no result loaded.
- Mid-range pulse: `hit` ↑ at 1405 ns, ↓ at 1475.1 ns → `bin_out_start` = 0 (edge coincident with clk), `bin_out_stop` = 31 (clamp), `out_count` = 8.
